// File: rtl/uart_frame_pkg.sv
// Shared state encoding, error codes and helpers for the UART RX frame parser.
package uart_frame_pkg;

    typedef enum logic [1:0] {
        ST_HUNT,
        ST_LEN,
        ST_PAYLOAD,
        ST_CHK
    } frame_state_t;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_LEN  = 2'b01;
    localparam logic [1:0] ERR_CHK  = 2'b10;
    localparam logic [1:0] ERR_TMO  = 2'b11;

    localparam logic [7:0] DEFAULT_SOF = 8'hA5;

    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/uart_rx_frame_parser_if.sv
// Payload stream from the frame parser to its sink (valid/ready with frame markers).
interface uart_rx_frame_parser_if #(
    parameter int W = 8
);
    logic [W-1:0] pl_data;
    logic         pl_valid;
    logic         pl_ready;
    logic         pl_first;
    logic         pl_last;

    modport master (output pl_data, output pl_valid, output pl_first, output pl_last,
                    input  pl_ready);
    modport slave  (input  pl_data, input  pl_valid, input  pl_first, input  pl_last,
                    output pl_ready);
endinterface

// File: rtl/uart_frame_timer.sv
// Mid-frame idle counter; expire is asserted during the TimeoutCycles-th consecutive idle clock.
module uart_frame_timer #(
    parameter int TimeoutCycles = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);
    localparam int CW = $clog2(TimeoutCycles + 1);
    localparam logic [CW-1:0] LAST = CW'(TimeoutCycles - 1);

    logic [CW-1:0] count;

    // Clear has priority so a pop in the expiry cycle cancels the timeout.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable && count != LAST) begin
            count <= count + CW'(1);
        end
    end

    assign expire = enable && !clear && (count == LAST);

endmodule

// File: rtl/uart_rx_frame_parser.sv
// Frame parser behind the UART RX FIFO: SOF, LEN, payload, XOR checksum; cut-through payload stream.
module uart_rx_frame_parser
    import uart_frame_pkg::*;
#(
    parameter int         DataBits      = 9,
    parameter int         MaxLen        = 64,
    parameter logic [7:0] SOF           = DEFAULT_SOF,
    parameter int         TimeoutCycles = 50000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DataBits-2:0]   r_data,
    input  logic                  R_empty,
    output logic                  rd_en,
    uart_rx_frame_parser_if.master pl,
    output logic                  frame_ok,
    output logic                  frame_err,
    output logic [1:0]            err_code,
    output logic [7:0]            frame_len,
    output logic [15:0]           ok_cnt,
    output logic [15:0]           err_cnt,
    output logic [15:0]           drop_cnt
);
    localparam logic [7:0] MAX_LEN_B = 8'(MaxLen);

    frame_state_t state;
    logic [7:0]   in_byte;
    logic [7:0]   len_q;
    logic [7:0]   chk_q;
    logic [7:0]   remaining;
    logic         tmo_clear;
    logic         tmo_enable;
    logic         timed_out;

    assign in_byte = r_data[7:0];

    // Bytes are never popped during reset because the FIFO keeps its contents across it.
    always_comb begin
        rd_en = 1'b0;
        if (!R_empty && !reset) begin
            case (state)
                ST_HUNT, ST_LEN: rd_en = 1'b1;
                ST_PAYLOAD:      rd_en = !pl.pl_valid || pl.pl_ready;
                ST_CHK:          rd_en = !pl.pl_valid;
                default:         rd_en = 1'b0;
            endcase
        end
    end

    assign tmo_clear  = rd_en || (state == ST_HUNT);
    assign tmo_enable = (state != ST_HUNT) && R_empty;

    uart_frame_timer #(
        .TimeoutCycles(TimeoutCycles)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (tmo_clear),
        .enable (tmo_enable),
        .expire (timed_out)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_HUNT;
            len_q       <= '0;
            chk_q       <= '0;
            remaining   <= '0;
            pl.pl_data  <= '0;
            pl.pl_valid <= 1'b0;
            pl.pl_first <= 1'b0;
            pl.pl_last  <= 1'b0;
            frame_ok    <= 1'b0;
            frame_err   <= 1'b0;
            err_code    <= ERR_NONE;
            frame_len   <= '0;
            ok_cnt      <= '0;
            err_cnt     <= '0;
            drop_cnt    <= '0;
        end else begin
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;

            if (pl.pl_valid && pl.pl_ready) begin
                pl.pl_valid <= 1'b0;
                pl.pl_first <= 1'b0;
                pl.pl_last  <= 1'b0;
            end

            // A timeout abandons the frame and drops any byte the sink has not taken yet.
            if (timed_out) begin
                pl.pl_valid <= 1'b0;
                pl.pl_first <= 1'b0;
                pl.pl_last  <= 1'b0;
                frame_err   <= 1'b1;
                err_code    <= ERR_TMO;
                frame_len   <= len_q;
                err_cnt     <= sat_inc16(err_cnt);
                state       <= ST_HUNT;
            end else if (rd_en) begin
                case (state)
                    ST_HUNT: begin
                        if (in_byte == SOF) begin
                            state <= ST_LEN;
                        end else begin
                            drop_cnt <= sat_inc16(drop_cnt);
                        end
                    end

                    ST_LEN: begin
                        if (in_byte == 8'h00 || in_byte > MAX_LEN_B) begin
                            frame_err <= 1'b1;
                            err_code  <= ERR_LEN;
                            frame_len <= in_byte;
                            err_cnt   <= sat_inc16(err_cnt);
                            state     <= ST_HUNT;
                        end else begin
                            len_q     <= in_byte;
                            chk_q     <= in_byte;
                            remaining <= in_byte;
                            state     <= ST_PAYLOAD;
                        end
                    end

                    ST_PAYLOAD: begin
                        pl.pl_data  <= r_data;
                        pl.pl_valid <= 1'b1;
                        pl.pl_first <= (remaining == len_q);
                        pl.pl_last  <= (remaining == 8'd1);
                        chk_q       <= chk_q ^ in_byte;
                        remaining   <= remaining - 8'd1;
                        if (remaining == 8'd1) begin
                            state <= ST_CHK;
                        end
                    end

                    ST_CHK: begin
                        frame_len <= len_q;
                        if ((chk_q ^ in_byte) == 8'h00) begin
                            frame_ok <= 1'b1;
                            ok_cnt   <= sat_inc16(ok_cnt);
                        end else begin
                            frame_err <= 1'b1;
                            err_code  <= ERR_CHK;
                            err_cnt   <= sat_inc16(err_cnt);
                        end
                        state <= ST_HUNT;
                    end

                    default: state <= ST_HUNT;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_frame_parser.sv
// Directed testbench for uart_rx_frame_parser with a behavioural FWFT FIFO and a payload monitor.
module tb_uart_rx_frame_parser;
    localparam int DATA_BITS = 9;
    localparam int W         = DATA_BITS - 1;
    localparam int TMO       = 20;

    logic         clk   = 1'b0;
    logic         reset = 1'b1;
    logic [W-1:0] r_data;
    logic         r_empty;
    logic         rd_en;
    logic         frame_ok;
    logic         frame_err;
    logic [1:0]   err_code;
    logic [7:0]   frame_len;
    logic [15:0]  ok_cnt;
    logic [15:0]  err_cnt;
    logic [15:0]  drop_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    uart_rx_frame_parser_if #(.W(W)) pl_if ();

    uart_rx_frame_parser #(
        .DataBits      (DATA_BITS),
        .MaxLen        (64),
        .SOF           (8'hA5),
        .TimeoutCycles (TMO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .r_data    (r_data),
        .R_empty   (r_empty),
        .rd_en     (rd_en),
        .pl        (pl_if),
        .frame_ok  (frame_ok),
        .frame_err (frame_err),
        .err_code  (err_code),
        .frame_len (frame_len),
        .ok_cnt    (ok_cnt),
        .err_cnt   (err_cnt),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    // First-word-fall-through FIFO model feeding the parser.
    logic [7:0] fifo_mem [0:255];
    int wr_ptr = 0;
    int rd_ptr = 0;
    assign r_empty = (rd_ptr == wr_ptr);
    assign r_data  = fifo_mem[rd_ptr[7:0]];
    always @(posedge clk) if (rd_en && !r_empty) rd_ptr <= rd_ptr + 1;

    // Monitor: records accepted payload bytes, pop times and protocol violations.
    int         cyc           = 0;
    int         cap_n         = 0;
    int         last_pop_cyc  = 0;
    int         both_pulses   = 0;
    int         rd_when_empty = 0;
    logic [7:0] cap_data  [0:255];
    logic       cap_first [0:255];
    logic       cap_last  [0:255];
    int         cap_cyc   [0:255];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (pl_if.pl_valid && pl_if.pl_ready) begin
            cap_data[cap_n[7:0]]  <= pl_if.pl_data;
            cap_first[cap_n[7:0]] <= pl_if.pl_first;
            cap_last[cap_n[7:0]]  <= pl_if.pl_last;
            cap_cyc[cap_n[7:0]]   <= cyc;
            cap_n                 <= cap_n + 1;
        end
        if (rd_en) last_pop_cyc <= cyc + 1;
        if (rd_en && r_empty) rd_when_empty <= rd_when_empty + 1;
        if (frame_ok && frame_err) both_pulses <= both_pulses + 1;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push(input logic [7:0] b);
        fifo_mem[wr_ptr[7:0]] = b;
        wr_ptr++;
    endtask

    task automatic push_good_short();
        push(8'hA5); push(8'h01); push(8'h7E); push(8'h7F);
    endtask

    task automatic wait_status(input int max_cycles, output logic got_ok, output logic got_err,
                               output bit got);
        got = 0; got_ok = 1'b0; got_err = 1'b0;
        for (int i = 0; i < max_cycles && !got; i++) begin
            tick();
            if (frame_ok || frame_err) begin
                got = 1; got_ok = frame_ok; got_err = frame_err;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        pl_if.pl_ready = 1'b1;
        repeat (3) tick();
        n_checks++; if (rd_en !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_rd_en: got %b expected 0", rd_en); end
        n_checks++; if ({pl_if.pl_valid, pl_if.pl_first, pl_if.pl_last} !== 3'b000) begin n_fail++; $display("[TB] FAIL reset_pl: got %b%b%b expected 000", pl_if.pl_valid, pl_if.pl_first, pl_if.pl_last); end
        n_checks++; if ({frame_ok, frame_err, err_code} !== 4'b0000) begin n_fail++; $display("[TB] FAIL reset_status: got %b%b%b expected 0000", frame_ok, frame_err, err_code); end
        n_checks++; if ({ok_cnt, err_cnt, drop_cnt} !== 48'd0) begin n_fail++; $display("[TB] FAIL reset_counters: got %h %h %h expected 0", ok_cnt, err_cnt, drop_cnt); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_good_frame();
        int base; logic gok, gerr; bit got;
        logic [7:0] exp_b [3];
        exp_b = '{8'h11, 8'h22, 8'h33};
        base = cap_n;
        push(8'hA5); push(8'h03); push(8'h11); push(8'h22); push(8'h33); push(8'h03);
        wait_status(60, gok, gerr, got);
        n_checks++; if (got !== 1'b1 || gok !== 1'b1 || gerr !== 1'b0) begin n_fail++; $display("[TB] FAIL good_status: got done=%b ok=%b err=%b expected 1 1 0", got, gok, gerr); end
        n_checks++; if (frame_len !== 8'd3) begin n_fail++; $display("[TB] FAIL good_len: got %0d expected 3", frame_len); end
        n_checks++; if (ok_cnt !== 16'd1) begin n_fail++; $display("[TB] FAIL good_ok_cnt: got %0d expected 1", ok_cnt); end
        n_checks++; if (cap_n - base !== 3) begin n_fail++; $display("[TB] FAIL good_count: got %0d expected 3", cap_n - base); end
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (cap_data[8'(base + k)] !== exp_b[k] || cap_first[8'(base + k)] !== (k == 0) || cap_last[8'(base + k)] !== (k == 2)) begin
                n_fail++;
                $display("[TB] FAIL good_byte%0d: got %h f=%b l=%b expected %h f=%b l=%b", k, cap_data[8'(base + k)], cap_first[8'(base + k)], cap_last[8'(base + k)], exp_b[k], k == 0, k == 2);
            end
        end
        n_checks++; if (cap_cyc[8'(base + 2)] - cap_cyc[8'(base)] !== 2) begin n_fail++; $display("[TB] FAIL good_throughput: got span %0d expected 2", cap_cyc[8'(base + 2)] - cap_cyc[8'(base)]); end
    endtask

    task automatic test_bad_checksum();
        int base; logic gok, gerr; bit got;
        base = cap_n;
        push(8'hA5); push(8'h03); push(8'h11); push(8'h22); push(8'h33); push(8'h04);
        wait_status(60, gok, gerr, got);
        n_checks++; if (got !== 1'b1 || gok !== 1'b0 || gerr !== 1'b1) begin n_fail++; $display("[TB] FAIL chk_status: got done=%b ok=%b err=%b expected 1 0 1", got, gok, gerr); end
        n_checks++; if (err_code !== 2'b10) begin n_fail++; $display("[TB] FAIL chk_code: got %b expected 10", err_code); end
        n_checks++; if (err_cnt !== 16'd1 || ok_cnt !== 16'd1) begin n_fail++; $display("[TB] FAIL chk_counters: got err=%0d ok=%0d expected 1 1", err_cnt, ok_cnt); end
        n_checks++; if (frame_len !== 8'd3) begin n_fail++; $display("[TB] FAIL chk_len: got %0d expected 3", frame_len); end
        n_checks++; if (cap_n - base !== 3 || cap_data[8'(base + 2)] !== 8'h33) begin n_fail++; $display("[TB] FAIL chk_payload: got %0d bytes last %h expected 3 bytes last 33", cap_n - base, cap_data[8'(base + 2)]); end
    endtask

    task automatic test_bad_len();
        int base; logic gok, gerr; bit got;
        base = cap_n;
        push(8'h00); push(8'hFF); push(8'hA5); push(8'h00);
        wait_status(30, gok, gerr, got);
        n_checks++; if (got !== 1'b1 || gerr !== 1'b1 || gok !== 1'b0) begin n_fail++; $display("[TB] FAIL len_status: got done=%b ok=%b err=%b expected 1 0 1", got, gok, gerr); end
        n_checks++; if (err_code !== 2'b01) begin n_fail++; $display("[TB] FAIL len_code: got %b expected 01", err_code); end
        n_checks++; if (drop_cnt !== 16'd2) begin n_fail++; $display("[TB] FAIL len_drop_cnt: got %0d expected 2", drop_cnt); end
        n_checks++; if (err_cnt !== 16'd2) begin n_fail++; $display("[TB] FAIL len_err_cnt: got %0d expected 2", err_cnt); end
        n_checks++; if (cap_n !== base) begin n_fail++; $display("[TB] FAIL len_no_payload: got %0d bytes expected 0", cap_n - base); end
        push_good_short();
        wait_status(30, gok, gerr, got);
        n_checks++; if (got !== 1'b1 || gok !== 1'b1) begin n_fail++; $display("[TB] FAIL len_recover: got done=%b ok=%b expected 1 1", got, gok); end
        n_checks++; if (ok_cnt !== 16'd2 || frame_len !== 8'd1 || drop_cnt !== 16'd2) begin n_fail++; $display("[TB] FAIL len_recover_stats: got ok=%0d len=%0d drop=%0d expected 2 1 2", ok_cnt, frame_len, drop_cnt); end
        n_checks++; if (cap_n - base !== 1 || cap_data[8'(base)] !== 8'h7E || {cap_first[8'(base)], cap_last[8'(base)]} !== 2'b11) begin n_fail++; $display("[TB] FAIL len_recover_byte: got n=%0d %h fl=%b%b expected 1 7e 11", cap_n - base, cap_data[8'(base)], cap_first[8'(base)], cap_last[8'(base)]); end
    endtask

    task automatic test_stall();
        int base; logic gok, gerr; bit got; bit seen;
        logic [7:0] exp_b [3];
        exp_b = '{8'h11, 8'h22, 8'h33};
        base = cap_n;
        seen = 0;
        push(8'hA5); push(8'h03); push(8'h11); push(8'h22); push(8'h33); push(8'h03);
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            if (pl_if.pl_valid) seen = 1;
        end
        pl_if.pl_ready = 1'b0;
        n_checks++; if (seen !== 1'b1 || pl_if.pl_data !== 8'h11) begin n_fail++; $display("[TB] FAIL stall_first: got seen=%b data=%h expected 1 11", seen, pl_if.pl_data); end
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++; if (rd_en !== 1'b0 || pl_if.pl_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL stall_hold%0d: got rd_en=%b valid=%b expected 0 1", i, rd_en, pl_if.pl_valid); end
        end
        pl_if.pl_ready = 1'b1;
        wait_status(60, gok, gerr, got);
        n_checks++; if (got !== 1'b1 || gok !== 1'b1 || gerr !== 1'b0) begin n_fail++; $display("[TB] FAIL stall_status: got done=%b ok=%b err=%b expected 1 1 0", got, gok, gerr); end
        n_checks++; if (cap_n - base !== 3) begin n_fail++; $display("[TB] FAIL stall_count: got %0d expected 3", cap_n - base); end
        for (int k = 0; k < 3; k++) begin
            n_checks++; if (cap_data[8'(base + k)] !== exp_b[k]) begin n_fail++; $display("[TB] FAIL stall_byte%0d: got %h expected %h", k, cap_data[8'(base + k)], exp_b[k]); end
        end
        n_checks++; if (ok_cnt !== 16'd3 || err_cnt !== 16'd2) begin n_fail++; $display("[TB] FAIL stall_counters: got ok=%0d err=%0d expected 3 2", ok_cnt, err_cnt); end
    endtask

    task automatic test_timeout();
        int base; logic gok, gerr; bit got;
        base = cap_n;
        pl_if.pl_ready = 1'b0;
        push(8'hA5); push(8'h02); push(8'h11);
        wait_status(80, gok, gerr, got);
        n_checks++; if (got !== 1'b1 || gerr !== 1'b1 || gok !== 1'b0) begin n_fail++; $display("[TB] FAIL tmo_status: got done=%b ok=%b err=%b expected 1 0 1", got, gok, gerr); end
        n_checks++; if (err_code !== 2'b11) begin n_fail++; $display("[TB] FAIL tmo_code: got %b expected 11", err_code); end
        n_checks++; if (cyc - last_pop_cyc !== TMO) begin n_fail++; $display("[TB] FAIL tmo_latency: got %0d expected %0d", cyc - last_pop_cyc, TMO); end
        n_checks++; if (pl_if.pl_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL tmo_flush: got valid=%b expected 0", pl_if.pl_valid); end
        n_checks++; if (err_cnt !== 16'd3 || frame_len !== 8'd2) begin n_fail++; $display("[TB] FAIL tmo_stats: got err=%0d len=%0d expected 3 2", err_cnt, frame_len); end
        pl_if.pl_ready = 1'b1;
        tick();
        n_checks++; if (cap_n !== base) begin n_fail++; $display("[TB] FAIL tmo_no_payload: got %0d bytes expected 0", cap_n - base); end
        push_good_short();
        wait_status(30, gok, gerr, got);
        n_checks++; if (got !== 1'b1 || gok !== 1'b1 || ok_cnt !== 16'd4) begin n_fail++; $display("[TB] FAIL tmo_recover: got done=%b ok=%b ok_cnt=%0d expected 1 1 4", got, gok, ok_cnt); end
    endtask

    task automatic test_reset_mid();
        logic gok, gerr; bit got; int pulses;
        pulses = 0;
        push(8'hA5); push(8'h04); push(8'h11); push(8'h22);
        for (int i = 0; i < 20 && !r_empty; i++) tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++; if ({pl_if.pl_valid, pl_if.pl_first, pl_if.pl_last, frame_ok, frame_err, err_code} !== 7'd0) begin n_fail++; $display("[TB] FAIL rst_mid_outputs: got %b%b%b%b%b%b expected 0", pl_if.pl_valid, pl_if.pl_first, pl_if.pl_last, frame_ok, frame_err, err_code); end
        n_checks++; if ({ok_cnt, err_cnt, drop_cnt, frame_len} !== 56'd0) begin n_fail++; $display("[TB] FAIL rst_mid_stats: got %h %h %h %h expected 0", ok_cnt, err_cnt, drop_cnt, frame_len); end
        for (int i = 0; i < 30; i++) begin
            tick();
            if (frame_ok || frame_err) pulses++;
        end
        n_checks++; if (pulses !== 0) begin n_fail++; $display("[TB] FAIL rst_mid_no_pulse: got %0d pulses expected 0", pulses); end
        push_good_short();
        wait_status(30, gok, gerr, got);
        n_checks++; if (got !== 1'b1 || gok !== 1'b1 || ok_cnt !== 16'd1 || err_cnt !== 16'd0) begin n_fail++; $display("[TB] FAIL rst_mid_recover: got done=%b ok=%b ok_cnt=%0d err_cnt=%0d expected 1 1 1 0", got, gok, ok_cnt, err_cnt); end
    endtask

    initial begin
        $display("[TB] starting uart_rx_frame_parser bench");
        test_reset();
        test_good_frame();
        test_bad_checksum();
        test_bad_len();
        test_stall();
        test_timeout();
        test_reset_mid();
        n_checks++; if (both_pulses !== 0) begin n_fail++; $display("[TB] FAIL pulse_exclusive: got %0d overlaps expected 0", both_pulses); end
        n_checks++; if (rd_when_empty !== 0) begin n_fail++; $display("[TB] FAIL rd_en_empty: got %0d pops while empty expected 0", rd_when_empty); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
